// File: rtl/csm_multiport.sv
// N-port controlled shared memory: round-robin arbitration over a single DEPTH x W
// array, muxed address/data per port, and an exclusive hold/release lock.
module csm_multiport #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned W         = 8,
    parameter int unsigned DEPTH     = 256,
    localparam int unsigned IW       = $clog2(NUM_PORTS)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_PORTS-1:0]   port_enable,
    input  logic [NUM_PORTS-1:0]   port_rw,
    input  logic [NUM_PORTS-1:0]   port_hold,
    input  logic [NUM_PORTS-1:0]   port_release,
    input  logic [NUM_PORTS*W-1:0] port_in_ad,
    output logic [NUM_PORTS-1:0]   port_gnt,
    output logic [NUM_PORTS-1:0]   port_ack,
    output logic [NUM_PORTS*W-1:0] port_out_data,
    output logic [NUM_PORTS*2-1:0] port_err,
    output logic                   lock_valid,
    output logic [IW-1:0]          lock_owner
);

    localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned IW1 = IW + 1;

    typedef enum logic {S_IDLE, S_ACCESS} state_t;

    state_t               r_state, w_state_nxt;
    logic [IW-1:0]        r_rr, r_idx, r_lock_owner;
    logic [IW-1:0]        w_off, w_sel, w_rr_nxt, w_hold_sel;
    logic                 r_rw, r_lock_valid;
    logic                 w_any_req, w_any_hold, w_grant, w_done, w_we;
    logic [AW-1:0]        r_addr;
    logic [1:0]           r_err, w_err_grant;
    logic [NUM_PORTS-1:0] r_gnt, r_ack, w_rot;
    logic [W-1:0]         r_out_data [NUM_PORTS];
    logic [1:0]           r_err_out  [NUM_PORTS];
    logic [W-1:0]         w_ad       [NUM_PORTS];
    logic [W-1:0]         mem        [DEPTH];

    // Modulo-NUM_PORTS reduction of a port index sum that is below 2*NUM_PORTS
    function automatic logic [IW-1:0] f_wrap(input logic [IW:0] s);
        return (s >= IW1'(NUM_PORTS)) ? IW'(s - IW1'(NUM_PORTS)) : IW'(s);
    endfunction

    // Flatten/unflatten the per-port buses
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_ad[p]                   = port_in_ad[p*W +: W];
            port_out_data[p*W +: W]   = r_out_data[p];
            port_err[p*2 +: 2]        = r_err_out[p];
        end
    end

    // Round-robin pick: rotate so r_rr sits at bit 0, take the lowest set bit
    always_comb begin
        w_rot     = NUM_PORTS'({port_enable, port_enable} >> r_rr);
        w_any_req = 1'b0;
        w_off     = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_any_req = 1'b1;
                w_off     = IW'(k);
            end
        end
        w_sel    = f_wrap(IW1'(r_rr) + IW1'(w_off));
        w_rr_nxt = f_wrap(IW1'(w_sel) + IW1'(1));
    end

    // Lowest-index hold requester
    always_comb begin
        w_any_hold = 1'b0;
        w_hold_sel = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (port_hold[k]) begin
                w_any_hold = 1'b1;
                w_hold_sel = IW'(k);
            end
        end
    end

    // Status is fixed at grant time; lock-out outranks range error
    always_comb begin
        w_err_grant = 2'b00;
        if (r_lock_valid && (r_lock_owner != w_sel)) begin
            w_err_grant = 2'b01;
        end else if (32'(w_ad[w_sel]) >= DEPTH) begin
            w_err_grant = 2'b10;
        end
    end

    // FSM next state
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_grant     = 1'b1;
                    w_state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_we = w_done && !r_rw && (r_err == 2'b00);

    // FSM state and access datapath
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_rr    <= '0;
            r_idx   <= '0;
            r_addr  <= '0;
            r_rw    <= 1'b0;
            r_err   <= 2'b00;
            r_gnt   <= '0;
            r_ack   <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                r_out_data[p] <= '0;
                r_err_out[p]  <= 2'b00;
            end
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= '0;
            r_ack   <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                r_err_out[p] <= 2'b00;
            end
            if (w_grant) begin
                r_gnt  <= NUM_PORTS'(1) << w_sel;
                r_rr   <= w_rr_nxt;
                r_idx  <= w_sel;
                r_addr <= w_ad[w_sel][AW-1:0];
                r_rw   <= port_rw[w_sel];
                r_err  <= w_err_grant;
            end
            if (w_done) begin
                r_ack <= NUM_PORTS'(1) << r_idx;
                for (int p = 0; p < NUM_PORTS; p++) begin
                    if (r_idx == IW'(p)) begin
                        r_err_out[p] <= r_err;
                        if (r_rw) begin
                            r_out_data[p] <= (r_err == 2'b00) ? mem[r_addr] : '0;
                        end
                    end
                end
            end
        end
    end

    // Array contents survive reset
    always_ff @(posedge clk) begin
        if (w_we) begin
            mem[r_addr] <= w_ad[r_idx];
        end
    end

    // Lock: release by owner wins; holds only count while the lock is free
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lock_valid <= 1'b0;
            r_lock_owner <= '0;
        end else if (r_lock_valid) begin
            if (port_release[r_lock_owner]) begin
                r_lock_valid <= 1'b0;
                r_lock_owner <= '0;
            end
        end else if (w_any_hold) begin
            r_lock_valid <= 1'b1;
            r_lock_owner <= w_hold_sel;
        end
    end

    assign port_gnt   = r_gnt;
    assign port_ack   = r_ack;
    assign lock_valid = r_lock_valid;
    assign lock_owner = r_lock_owner;

endmodule

// File: tb/tb_csm_multiport.sv
// Directed bench for csm_multiport: vector table of single accesses plus
// hand-written arbitration, lock and reset sequences.
module tb_csm_multiport;

    localparam int unsigned N     = 4;
    localparam int unsigned W     = 8;
    localparam int unsigned DEPTH = 200;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [N-1:0]   port_enable, port_rw, port_hold, port_release;
    logic [N*W-1:0] port_in_ad;
    logic [N-1:0]   port_gnt, port_ack;
    logic [N*W-1:0] port_out_data;
    logic [N*2-1:0] port_err;
    logic           lock_valid;
    logic [1:0]     lock_owner;

    int checks = 0;
    int errors = 0;

    csm_multiport #(.NUM_PORTS(N), .W(W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n),
        .port_enable(port_enable), .port_rw(port_rw),
        .port_hold(port_hold), .port_release(port_release),
        .port_in_ad(port_in_ad),
        .port_gnt(port_gnt), .port_ack(port_ack),
        .port_out_data(port_out_data), .port_err(port_err),
        .lock_valid(lock_valid), .lock_owner(lock_owner)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         port;
        logic       rw;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [1:0] err;
        logic [7:0] rdata;
    } vec_t;

    vec_t vecs [12];

    localparam logic [3:0] T2_GNT [9] = '{4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1};
    localparam logic [3:0] T2_ACK [9] = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_ad(input int p, input logic [7:0] v);
        port_in_ad[p*W +: W] = v;
    endtask

    // One access: request at a negedge, sample gnt one cycle later, ack two cycles later
    task automatic access(input int p, input logic rw, input logic [7:0] a, input logic [7:0] d,
                          output logic [3:0] g, output logic [3:0] ak,
                          output logic [1:0] e, output logic [7:0] rd);
        @(negedge clk);
        port_enable[p] = 1'b1;
        port_rw[p]     = rw;
        set_ad(p, a);
        @(negedge clk);
        g              = port_gnt;
        port_enable[p] = 1'b0;
        set_ad(p, d);
        @(negedge clk);
        ak = port_ack;
        e  = port_err[p*2 +: 2];
        rd = port_out_data[p*W +: W];
        set_ad(p, 8'h00);
    endtask

    task automatic check_access(input string tag, input int p, input logic rw,
                                input logic [7:0] a, input logic [7:0] d,
                                input logic [1:0] exp_err, input logic [7:0] exp_rd);
        logic [3:0] g, ak;
        logic [1:0] e;
        logic [7:0] rd;
        access(p, rw, a, d, g, ak, e, rd);
        chk({tag, "_gnt"}, 32'(g), 32'(1 << p));
        chk({tag, "_ack"}, 32'(ak), 32'(1 << p));
        chk({tag, "_err"}, 32'(e), 32'(exp_err));
        if (rw) chk({tag, "_rdata"}, 32'(rd), 32'(exp_rd));
    endtask

    task automatic pulse_lock(input logic [3:0] h, input logic [3:0] r);
        @(negedge clk);
        port_hold    = h;
        port_release = r;
        @(negedge clk);
        port_hold    = '0;
        port_release = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_n      = 1'b0;
        port_enable  = '0;
        port_rw      = '0;
        port_hold    = '0;
        port_release = '0;
        port_in_ad   = '0;

        vecs[0]  = '{0, 1'b0, 8'h10, 8'hA5, 2'b00, 8'h00};
        vecs[1]  = '{0, 1'b1, 8'h10, 8'h00, 2'b00, 8'hA5};
        vecs[2]  = '{1, 1'b0, 8'h00, 8'h3C, 2'b00, 8'h00};
        vecs[3]  = '{2, 1'b0, 8'hC7, 8'h7E, 2'b00, 8'h00};
        vecs[4]  = '{3, 1'b1, 8'hC7, 8'h00, 2'b00, 8'h7E};
        vecs[5]  = '{1, 1'b1, 8'h00, 8'h00, 2'b00, 8'h3C};
        vecs[6]  = '{3, 1'b0, 8'hC8, 8'h55, 2'b10, 8'h00};
        vecs[7]  = '{3, 1'b1, 8'hC8, 8'h00, 2'b10, 8'h00};
        vecs[8]  = '{2, 1'b0, 8'hFF, 8'h99, 2'b10, 8'h00};
        vecs[9]  = '{0, 1'b0, 8'h20, 8'h5A, 2'b00, 8'h00};
        vecs[10] = '{2, 1'b1, 8'h10, 8'h00, 2'b00, 8'hA5};
        vecs[11] = '{3, 1'b0, 8'h30, 8'h77, 2'b00, 8'h00};

        repeat (2) @(negedge clk);
        chk("reset_ctrl", 32'({port_gnt, port_ack, port_err, lock_valid, lock_owner}), 32'h0);
        chk("reset_data", 32'(port_out_data), 32'h0);
        reset_n = 1'b1;

        // All four ports request together from reset: grant order 0,1,2,3 then wrap to 0
        port_rw = 4'hF;
        for (int p = 0; p < 4; p++) set_ad(p, 8'h10);
        port_enable = 4'hF;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            chk($sformatf("rr_gnt_c%0d", c), 32'(port_gnt), 32'(T2_GNT[c]));
            chk($sformatf("rr_ack_c%0d", c), 32'(port_ack), 32'(T2_ACK[c]));
        end
        port_enable = '0;
        @(negedge clk);
        chk("rr_wrap_ack", 32'(port_ack), 32'h1);

        for (int i = 0; i < 12; i++) begin
            check_access($sformatf("v%0d", i), vecs[i].port, vecs[i].rw, vecs[i].addr,
                         vecs[i].wdata, vecs[i].err, vecs[i].rdata);
        end

        // Lock by P1; other ports locked out with no memory effect
        pulse_lock(4'b0010, 4'b0000);
        chk("t3_lock", 32'({lock_valid, lock_owner}), 32'({1'b1, 2'd1}));
        check_access("t3_p2w", 2, 1'b0, 8'h20, 8'h11, 2'b01, 8'h00);
        check_access("t3_p1r", 1, 1'b1, 8'h20, 8'h00, 2'b00, 8'h5A);
        check_access("t3_p0r", 0, 1'b1, 8'h20, 8'h00, 2'b01, 8'h00);
        pulse_lock(4'b0001, 4'b0100);
        chk("t3_nonowner", 32'({lock_valid, lock_owner}), 32'({1'b1, 2'd1}));
        pulse_lock(4'b1000, 4'b0010);
        chk("t3_release", 32'({lock_valid, lock_owner}), 32'h0);
        @(negedge clk);
        chk("t3_hold_ignored", 32'({lock_valid, lock_owner}), 32'h0);

        // Simultaneous holds: lowest index wins; owner hold+release clears
        pulse_lock(4'b0101, 4'b0000);
        chk("t5_lock", 32'({lock_valid, lock_owner}), 32'({1'b1, 2'd0}));
        check_access("t5_p0r", 0, 1'b1, 8'h10, 8'h00, 2'b00, 8'hA5);
        pulse_lock(4'b0001, 4'b0001);
        chk("t5_hold_rel", 32'({lock_valid, lock_owner}), 32'h0);

        // Reset during the access cycle of a write drops it
        @(negedge clk);
        port_enable[0] = 1'b1;
        port_rw[0]     = 1'b0;
        set_ad(0, 8'h30);
        @(negedge clk);
        chk("t6_gnt", 32'(port_gnt), 32'h1);
        port_enable[0] = 1'b0;
        set_ad(0, 8'hEE);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_ctrl", 32'({port_gnt, port_ack, port_err, lock_valid, lock_owner}), 32'h0);
        chk("t6_rst_data", 32'(port_out_data), 32'h0);
        @(negedge clk);
        chk("t6_no_ack0", 32'(port_ack), 32'h0);
        reset_n = 1'b1;
        set_ad(0, 8'h00);
        @(negedge clk);
        chk("t6_no_ack1", 32'(port_ack), 32'h0);
        check_access("t6_readback", 3, 1'b1, 8'h30, 8'h00, 2'b00, 8'h77);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
